// File: rtl/display_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | display_pkg: shared state encoding, blank code and width helper      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SHOW = 2'b01,
    AUTO = 2'b10
  } state_t;

  localparam logic [3:0] BLANK_DEFAULT = 4'hF;

  // Ceiling log2 that never returns less than one bit.
  function automatic int pos_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/display_window_scroller_window_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | window_select: picks WIN_DIGITS consecutive digits starting at pos   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module window_select #(
  parameter int                 NUM_DIGITS = 5,
  parameter int                 WIN_DIGITS = 3,
  parameter int                 DIGIT_W    = 4,
  parameter int                 POS_W      = 2,
  parameter logic [DIGIT_W-1:0] BLANK_CODE = '1
) (
  input  logic [NUM_DIGITS*DIGIT_W-1:0] data,
  input  logic [POS_W-1:0]              pos,
  input  logic                          blank,
  output logic [WIN_DIGITS*DIGIT_W-1:0] win_out
);

  localparam int MAX_POS = NUM_DIGITS - WIN_DIGITS;

  genvar i;
  generate
    for (i = 0; i < WIN_DIGITS; i++) begin : g_digit
      logic [DIGIT_W-1:0] w_sel;

      // Iterating over legal offsets keeps every part-select constant and in range.
      always_comb begin
        w_sel = BLANK_CODE;
        if (!blank) begin
          for (int p = 0; p <= MAX_POS; p++) begin
            if (pos == POS_W'(p)) begin
              w_sel = data[(p+i)*DIGIT_W +: DIGIT_W];
            end
          end
        end
      end

      assign win_out[i*DIGIT_W +: DIGIT_W] = w_sel;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/display_window_scroller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | display_window_scroller: captured BCD value shown through a scrolling|
// | window, manual or timer driven.            Revision: 1.0             |
// +----------------------------------------------------------------------+
module display_window_scroller
  import display_pkg::*;
#(
  parameter int                 NUM_DIGITS  = 5,
  parameter int                 WIN_DIGITS  = 3,
  parameter int                 DIGIT_W     = 4,
  parameter logic [DIGIT_W-1:0] BLANK_CODE  = DIGIT_W'(BLANK_DEFAULT),
  parameter int                 AUTO_PERIOD = 50_000_000,
  localparam int                MAX_POS     = NUM_DIGITS - WIN_DIGITS,
  localparam int                POS_W       = pos_width(MAX_POS + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic                          clear,
  input  logic                          scroll_left,
  input  logic                          scroll_right,
  input  logic                          auto_en,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] bcd_in,
  output logic [WIN_DIGITS*DIGIT_W-1:0] win_out,
  output logic [POS_W-1:0]              win_pos,
  output logic                          at_left,
  output logic                          at_right,
  output logic                          showing
);

  localparam int TICK_W = pos_width(AUTO_PERIOD);

  state_t                        state_q, state_d;
  logic [NUM_DIGITS*DIGIT_W-1:0] data_q, data_d;
  logic [POS_W-1:0]              pos_q, pos_d;
  logic [TICK_W-1:0]             tick_cnt_q, tick_cnt_d;

  logic w_move_l, w_move_r, w_manual, w_at_max, w_at_min, w_wrap;

  assign w_move_l = scroll_left & ~scroll_right;
  assign w_move_r = scroll_right & ~scroll_left;
  assign w_manual = scroll_left | scroll_right;
  assign w_at_max = (pos_q == POS_W'(MAX_POS));
  assign w_at_min = (pos_q == '0);
  assign w_wrap   = (tick_cnt_q == TICK_W'(AUTO_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      data_q     <= '0;
      pos_q      <= '0;
      tick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      pos_q      <= pos_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    pos_d      = pos_q;
    tick_cnt_d = tick_cnt_q;

    if (clear) begin
      state_d    = IDLE;
      pos_d      = '0;
      tick_cnt_d = '0;
    end else if (load) begin
      data_d     = bcd_in;
      pos_d      = '0;
      tick_cnt_d = '0;
      state_d    = auto_en ? AUTO : SHOW;
    end else if (state_q != IDLE) begin
      if (w_move_l && !w_at_max) pos_d = pos_q + POS_W'(1);
      if (w_move_r && !w_at_min) pos_d = pos_q - POS_W'(1);

      case (state_q)
        SHOW: begin
          if (auto_en) begin
            state_d    = AUTO;
            tick_cnt_d = '0;
          end
        end
        AUTO: begin
          if (!auto_en) begin
            state_d = SHOW;
          end else if (w_manual) begin
            tick_cnt_d = '0;
          end else if (w_wrap) begin
            // Marquee step: wraps back to the LS end after the MS end.
            tick_cnt_d = '0;
            pos_d      = w_at_max ? '0 : pos_q + POS_W'(1);
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  window_select #(
    .NUM_DIGITS (NUM_DIGITS),
    .WIN_DIGITS (WIN_DIGITS),
    .DIGIT_W    (DIGIT_W),
    .POS_W      (POS_W),
    .BLANK_CODE (BLANK_CODE)
  ) u_window_select (
    .data    (data_q),
    .pos     (pos_q),
    .blank   (state_q == IDLE),
    .win_out (win_out)
  );

  assign win_pos  = pos_q;
  assign at_left  = w_at_max;
  assign at_right = w_at_min;
  assign showing  = (state_q != IDLE);

endmodule
`default_nettype wire

// File: doc/display_window_scroller.md
Name: display_window_scroller

Overview:
- Sequential, parametrised successor of the 3-of-5 digit display selector.
- Captures an N-digit BCD product on a load pulse and presents a W-digit window to the seven-segment encoders.
- The window is moved by scroll pulses from the debounced buttons, or automatically by a built-in timer.
- Sits between the BCD converter and the segment encoders; the window position is registered state, not an external select.

Parameters:
NUM_DIGITS, 5, digits in captured BCD value (>= WIN_DIGITS)
WIN_DIGITS, 3, digits shown simultaneously (>= 1)
DIGIT_W, 4, bits per digit
BLANK_CODE, 4'hF, digit code the encoder renders as underscore
AUTO_PERIOD, 50_000_000, clk cycles between automatic scroll steps (>= 2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
load  in  1  single-cycle pulse: capture bcd_in, show rightmost window
clear  in  1  single-cycle pulse: return to blank display
scroll_left  in  1  single-cycle pulse: move window one digit toward MS digit
scroll_right  in  1  single-cycle pulse: move window one digit toward LS digit
auto_en  in  1  level: enable automatic scrolling while showing
bcd_in  in  NUM_DIGITS*DIGIT_W  BCD value, digit 0 in LSBs
win_out  out  WIN_DIGITS*DIGIT_W  displayed digits, window digit 0 in LSBs
win_pos  out  POS_W=clog2(MAX_POS+1), min 1  current window offset in digits from LS end
at_left  out  1  window at MS end (win_pos==MAX_POS)
at_right  out  1  window at LS end (win_pos==0)
showing  out  1  1 when not in IDLE

Behaviour:
- MAX_POS = NUM_DIGITS-WIN_DIGITS. All state is updated on the rising clk edge. Outputs are combinational functions of registered state, so an input pulse sampled at edge k is visible immediately after edge k.
- Registers: state_q (IDLE/SHOW/AUTO), data_q, pos_q, tick_cnt_q.
- Reset (rst_n=0 at edge): state_q=IDLE, data_q=0, pos_q=0, tick_cnt_q=0. Outputs: win_out all BLANK_CODE, win_pos=0, at_right=1, at_left=(MAX_POS==0), showing=0. Reset overrides every other input.
- IDLE: win_out = all BLANK_CODE. Scroll pulses are ignored.
- SHOW/AUTO: win_out digit i = data_q digit (pos_q+i).
- Input priority per edge: clear > load > scroll/auto step.
- clear: state_q->IDLE, pos_q->0, tick_cnt_q->0. data_q is retained.
- load: data_q<-bcd_in, pos_q<-0, tick_cnt_q<-0. state_q->AUTO if auto_en=1, else SHOW. load is legal in any state, including mid-scroll; it restarts the view.
- Manual scroll (SHOW or AUTO):
  - scroll_left: pos_q+1, saturating at MAX_POS.
  - scroll_right: pos_q-1, saturating at 0.
  - Both high in the same cycle: no move.
  - A manual scroll in AUTO also resets tick_cnt_q to 0.
- Mode changes:
  - SHOW with auto_en=1 -> AUTO; tick_cnt_q=0.
  - AUTO with auto_en=0 -> SHOW; pos_q is held.
- AUTO timer:
  - tick_cnt_q counts 0..AUTO_PERIOD-1 and wraps.
  - On the wrap cycle (no manual scroll, no load/clear): pos_q+1, wrapping from MAX_POS to 0.
  - Cyclic marquee; the first step occurs AUTO_PERIOD cycles after entering AUTO.
- MAX_POS==0: all moves are no-ops; at_left=at_right=1.
- Widths: tick counter is clog2(AUTO_PERIOD) bits. No arithmetic on digit values; BCD validity is not checked.

Decomposition:
- Package display_pkg holds:
  - state typedef (IDLE=2'b00, SHOW=2'b01, AUTO=2'b10)
  - BLANK_CODE default constant
  - a pos-width function: clog2 with a minimum of 1
- One combinational sub-module, window_select, takes data, pos and a blank flag and produces win_out. This generalises the old fixed select to any NUM_DIGITS/WIN_DIGITS.
- The FSM, position register and timer stay in the top module.

Test Plan:
1. Reset and blanking: rst_n=0 for 2 cycles, then release with no stimulus -> win_out=12'hFFF, win_pos=0, showing=0, at_right=1. Scroll pulses in IDLE leave all outputs unchanged.
2. Load and saturating left scroll (defaults, auto_en=0): load with bcd_in=20'h12345 -> win_out=12'h345. Then scroll_left x3, one every 2 cycles -> 12'h234, 12'h123, 12'h123, with win_pos=2 and at_left=1 after the 2nd pulse.
3. Right scroll and conflicts: from pos 2, scroll_right -> 12'h234. scroll_left and scroll_right in the same cycle -> 12'h234 held. scroll_right x2 -> 12'h345, at_right=1, pos stays 0.
4. Auto wrap (AUTO_PERIOD=4): load 20'h98765 with auto_en=1 -> 12'h765 for 4 cycles, then 12'h876 for 4, then 12'h987 for 4, then back to 12'h765. A manual scroll_left mid-period restarts the 4-cycle count.
5. Priority and mid-operation events: while in AUTO at pos 1:
   - clear and load in the same cycle -> IDLE, 12'hFFF.
   - load 20'h00042 then scroll_left in the same cycle -> pos 0, 12'h042.
   - rst_n=0 while win_pos=2 -> pos 0, blank on the next cycle.
6. Parameter sweep: NUM_DIGITS=3, WIN_DIGITS=3 -> load 12'h507 gives win_out=12'h507, at_left=at_right=1, and scrolls are no-ops. NUM_DIGITS=8, WIN_DIGITS=4 -> 4 left steps from pos 0 end at pos 4 showing the top 4 digits.
